// File: rtl/riscv32ima_pkg.sv
// Shared types and constants for the riscv32ima memory-side blocks.
package riscv32ima_pkg;

  localparam int ADDR_WIDTH = 32;
  localparam int DATA_WIDTH = 64;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD_I = 2'd1,
    HOLD_D = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } arb_owner_t;

endpackage

// File: rtl/riscv32ima_arb_starve.sv
// Saturating count of consecutive data acceptances while fetch is waiting.
module riscv32ima_arb_starve #(
  parameter int LIMIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic at_limit
);

  localparam int CW = $clog2(LIMIT + 1);
  localparam logic [CW-1:0] LIM = CW'(LIMIT);

  logic [CW-1:0] cnt_q, cnt_d;

  // Clear dominates so a fetch acceptance always restarts the window.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != LIM)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign at_limit = (cnt_q == LIM);

endmodule

// File: rtl/riscv32ima_mem_arbiter.sv
// Two-requester (fetch/data) arbiter onto one memory port, data-priority with a
// starvation guard, grant held across memory stalls, read data steered back.
module riscv32ima_mem_arbiter #(
  parameter int ADDR_WIDTH   = riscv32ima_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH   = riscv32ima_pkg::DATA_WIDTH,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_ncs,
  input  logic                  i_nwe,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic [DATA_WIDTH-1:0] i_wmask,
  output logic                  i_stall,
  output logic                  i_rvalid,
  output logic [DATA_WIDTH-1:0] i_rdata,
  input  logic                  d_ncs,
  input  logic                  d_nwe,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  input  logic [DATA_WIDTH-1:0] d_wmask,
  output logic                  d_stall,
  output logic                  d_rvalid,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic                  m_ncs,
  output logic                  m_nwe,
  output logic [ADDR_WIDTH-1:0] m_addr,
  output logic [DATA_WIDTH-1:0] m_wdata,
  output logic [DATA_WIDTH-1:0] m_wmask,
  input  logic [DATA_WIDTH-1:0] m_rdata,
  input  logic                  m_stall,
  output logic [1:0]            dbg_state_o
);

  import riscv32ima_pkg::*;

  // Handshake: a port with x_ncs=0 keeps every request field stable while
  // x_stall=1; the request is taken in the cycle x_stall drops to 0, and a
  // read taken in cycle N returns with x_rvalid=1 in cycle N+1.

  arb_state_t state_q, state_d;
  arb_owner_t resp_owner_q;
  logic       resp_pend_q;
  logic       gnt_i, gnt_d, accept, at_limit;
  logic       starve_inc, starve_clr;

  always_comb begin
    gnt_i = 1'b0;
    gnt_d = 1'b0;
    if (!rst) begin
      unique case (state_q)
        IDLE: begin
          gnt_i = !i_ncs && (d_ncs || at_limit);
          gnt_d = !d_ncs && !gnt_i;
        end
        HOLD_I: gnt_i = !i_ncs;
        HOLD_D: gnt_d = !d_ncs;
        default: begin
          gnt_i = 1'b0;
          gnt_d = 1'b0;
        end
      endcase
    end
  end

  assign accept  = (gnt_i || gnt_d) && !m_stall;
  assign i_stall = !i_ncs && !(gnt_i && !m_stall);
  assign d_stall = !d_ncs && !(gnt_d && !m_stall);

  always_comb begin
    m_ncs   = 1'b1;
    m_nwe   = 1'b1;
    m_addr  = '0;
    m_wdata = '0;
    m_wmask = '0;
    if (gnt_i) begin
      m_ncs   = 1'b0;
      m_nwe   = i_nwe;
      m_addr  = i_addr;
      m_wdata = i_wdata;
      m_wmask = i_wmask;
    end else if (gnt_d) begin
      m_ncs   = 1'b0;
      m_nwe   = d_nwe;
      m_addr  = d_addr;
      m_wdata = d_wdata;
      m_wmask = d_wmask;
    end
  end

  // A withdrawn hold yields no grant and so falls back to IDLE here.
  always_comb begin
    state_d = IDLE;
    if (gnt_i && m_stall) begin
      state_d = HOLD_I;
    end else if (gnt_d && m_stall) begin
      state_d = HOLD_D;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      resp_pend_q  <= 1'b0;
      resp_owner_q <= OWN_I;
    end else begin
      state_q     <= state_d;
      resp_pend_q <= accept && m_nwe;
      if (accept) begin
        resp_owner_q <= gnt_d ? OWN_D : OWN_I;
      end
    end
  end

  assign starve_inc = gnt_d && !m_stall && !i_ncs;
  assign starve_clr = (gnt_i && !m_stall) || i_ncs;

  riscv32ima_arb_starve #(
    .LIMIT(STARVE_LIMIT)
  ) u_starve (
    .clk     (clk),
    .rst     (rst),
    .inc     (starve_inc),
    .clr     (starve_clr),
    .at_limit(at_limit)
  );

  // Gated by rst so a response in flight when reset hits is never reported.
  assign i_rvalid    = !rst && resp_pend_q && (resp_owner_q == OWN_I);
  assign d_rvalid    = !rst && resp_pend_q && (resp_owner_q == OWN_D);
  assign i_rdata     = m_rdata;
  assign d_rdata     = m_rdata;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_riscv32ima_mem_arbiter.sv
// Directed bench for riscv32ima_mem_arbiter: reset, single fetch, contention
// with starvation guard, stall hold, withdrawal and reset during a read.
module tb_riscv32ima_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_ncs, i_nwe, d_ncs, d_nwe;
  logic [31:0] i_addr, d_addr;
  logic [63:0] i_wdata, i_wmask, d_wdata, d_wmask;
  logic        i_stall, i_rvalid, d_stall, d_rvalid;
  logic [63:0] i_rdata, d_rdata;
  logic        m_ncs, m_nwe;
  logic [31:0] m_addr;
  logic [63:0] m_wdata, m_wmask, m_rdata;
  logic        m_stall;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_err    = 0;
  logic [0:0] exp_q[$];

  always #5 clk = ~clk;

  riscv32ima_mem_arbiter #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(64),
    .STARVE_LIMIT(4)
  ) dut (
    .clk(clk), .rst(rst),
    .i_ncs(i_ncs), .i_nwe(i_nwe), .i_addr(i_addr), .i_wdata(i_wdata),
    .i_wmask(i_wmask), .i_stall(i_stall), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_ncs(d_ncs), .d_nwe(d_nwe), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_wmask(d_wmask), .d_stall(d_stall), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .m_ncs(m_ncs), .m_nwe(m_nwe), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_wmask(m_wmask), .m_rdata(m_rdata), .m_stall(m_stall),
    .dbg_state_o(dbg_state)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  initial begin
    logic exp_owner;
    logic prev_owner;

    rst = 1'b1;
    i_ncs = 1'b0; i_nwe = 1'b1; i_addr = 32'h1000_0000; i_wdata = '0; i_wmask = '0;
    d_ncs = 1'b0; d_nwe = 1'b1; d_addr = 32'h2000_0000; d_wdata = '0; d_wmask = '0;
    m_stall = 1'b0; m_rdata = '0;

    // Reset held two cycles with both requesters active.
    sample();
    chk("rst_m_ncs", m_ncs, 1);
    chk("rst_m_nwe", m_nwe, 1);
    chk("rst_m_addr", m_addr, 0);
    chk("rst_i_rvalid", i_rvalid, 0);
    chk("rst_d_rvalid", d_rvalid, 0);
    chk("rst_i_stall", i_stall, 1);
    chk("rst_d_stall", d_stall, 1);
    next_cycle();
    sample();
    chk("rst2_m_ncs", m_ncs, 1);
    chk("rst2_state", dbg_state, 2'd0);

    // Idle cycle: no grant.
    next_cycle();
    rst = 1'b0; i_ncs = 1'b1; d_ncs = 1'b1;
    sample();
    chk("idle_m_ncs", m_ncs, 1);
    chk("idle_m_addr", m_addr, 0);
    chk("idle_i_stall", i_stall, 0);

    // Fetch alone.
    next_cycle();
    i_ncs = 1'b0; i_addr = 32'h1000_0000;
    sample();
    chk("fa_i_stall", i_stall, 0);
    chk("fa_m_ncs", m_ncs, 0);
    chk("fa_m_addr", m_addr, 32'h1000_0000);
    next_cycle();
    i_ncs = 1'b1; m_rdata = 64'hDEAD_BEEF_0000_0013;
    sample();
    chk("fa_i_rvalid", i_rvalid, 1);
    chk("fa_i_rdata", i_rdata, 64'hDEAD_BEEF_0000_0013);
    chk("fa_d_rvalid", d_rvalid, 0);

    // Contention: expected grants D,D,D,D,I,D,D,D,D,I (1 = data).
    for (int k = 0; k < 10; k++) begin
      next_cycle();
      i_ncs = 1'b0; i_addr = 32'h1000_0008;
      d_ncs = 1'b0; d_addr = 32'h2000_0000; d_nwe = 1'b1;
      m_rdata = 64'h0000_0000_0000_1000 + 64'(k);
      sample();
      exp_owner = (k == 4 || k == 9) ? 1'b0 : 1'b1;
      chk($sformatf("ct_m_addr_%0d", k), m_addr, exp_owner ? 32'h2000_0000 : 32'h1000_0008);
      chk($sformatf("ct_i_stall_%0d", k), i_stall, exp_owner);
      chk($sformatf("ct_d_stall_%0d", k), d_stall, !exp_owner);
      if (exp_q.size() != 0) begin
        prev_owner = exp_q.pop_front();
        chk($sformatf("ct_i_rvalid_%0d", k), i_rvalid, !prev_owner);
        chk($sformatf("ct_d_rvalid_%0d", k), d_rvalid, prev_owner);
        chk($sformatf("ct_rdata_%0d", k), prev_owner ? d_rdata : i_rdata,
            64'h0000_0000_0000_1000 + 64'(k));
      end
      exp_q.push_back(exp_owner);
    end
    next_cycle();
    i_ncs = 1'b1; d_ncs = 1'b1; m_rdata = 64'h0000_0000_0000_2000;
    sample();
    prev_owner = exp_q.pop_front();
    chk("ct_last_i_rvalid", i_rvalid, !prev_owner);
    chk("ct_last_d_rvalid", d_rvalid, prev_owner);
    chk("ct_last_i_rdata", i_rdata, 64'h0000_0000_0000_2000);

    // Stall hold: data write held through three memory-stall cycles.
    for (int k = 0; k < 3; k++) begin
      next_cycle();
      d_ncs = 1'b0; d_nwe = 1'b0; d_addr = 32'h2000_0010;
      d_wdata = 64'h1122_3344_5566_7788; d_wmask = 64'h0000_0000_FFFF_FFFF;
      i_ncs = 1'b0; i_nwe = 1'b1; i_addr = 32'h1000_0010;
      m_stall = 1'b1;
      sample();
      chk($sformatf("sh_m_addr_%0d", k), m_addr, 32'h2000_0010);
      chk($sformatf("sh_d_stall_%0d", k), d_stall, 1);
      chk($sformatf("sh_i_stall_%0d", k), i_stall, 1);
      chk($sformatf("sh_m_nwe_%0d", k), m_nwe, 0);
      if (k > 0) chk($sformatf("sh_state_%0d", k), dbg_state, 2'd2);
    end
    next_cycle();
    m_stall = 1'b0;
    sample();
    chk("sh_acc_d_stall", d_stall, 0);
    chk("sh_acc_m_addr", m_addr, 32'h2000_0010);
    chk("sh_acc_m_wdata", m_wdata, 64'h1122_3344_5566_7788);
    chk("sh_acc_m_wmask", m_wmask, 64'h0000_0000_FFFF_FFFF);
    chk("sh_acc_i_stall", i_stall, 1);
    next_cycle();
    d_ncs = 1'b1; d_nwe = 1'b1;
    sample();
    chk("sh_no_d_rvalid", d_rvalid, 0);
    chk("sh_fetch_i_stall", i_stall, 0);
    chk("sh_fetch_m_addr", m_addr, 32'h1000_0010);
    next_cycle();
    i_ncs = 1'b1; m_rdata = 64'h0000_0000_0000_3000;
    sample();
    chk("sh_fetch_i_rvalid", i_rvalid, 1);

    // Withdrawal from HOLD_I.
    next_cycle();
    i_ncs = 1'b0; i_addr = 32'h1000_0020; m_stall = 1'b1;
    sample();
    chk("wd_i_stall", i_stall, 1);
    chk("wd_m_ncs_req", m_ncs, 0);
    next_cycle();
    i_ncs = 1'b1;
    sample();
    chk("wd_state_hold_i", dbg_state, 2'd1);
    chk("wd_m_ncs", m_ncs, 1);
    chk("wd_i_stall_off", i_stall, 0);
    next_cycle();
    m_stall = 1'b0;
    sample();
    chk("wd_state_idle", dbg_state, 2'd0);
    chk("wd_i_rvalid", i_rvalid, 0);
    chk("wd_d_rvalid", d_rvalid, 0);

    // Reset arriving the cycle after a read is accepted.
    next_cycle();
    d_ncs = 1'b0; d_nwe = 1'b1; d_addr = 32'h2000_0020;
    sample();
    chk("rm_d_stall", d_stall, 0);
    next_cycle();
    rst = 1'b1; d_ncs = 1'b1;
    sample();
    chk("rm_n1_d_rvalid", d_rvalid, 0);
    chk("rm_n1_i_rvalid", i_rvalid, 0);
    chk("rm_n1_m_ncs", m_ncs, 1);
    next_cycle();
    rst = 1'b0;
    sample();
    chk("rm_n2_d_rvalid", d_rvalid, 0);
    chk("rm_n2_i_rvalid", i_rvalid, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/riscv32ima_mem_arbiter.md
# riscv32ima_mem_arbiter

Shares a single unified memory port between the instruction-fetch requester and the load/store (data) requester of the riscv32ima core. It sits between the fetch stage's `i_*` port, the memory stage's `d_*` port, and the external `m_*` memory. It arbitrates each cycle, holds a grant while the memory stalls, and steers the one-cycle-latency read data back to its owner with a valid strobe. Data accesses win by default; a starvation guard ensures fetch progress.

## Interface
- `ADDR_WIDTH`, 32, address width, all ports
- `DATA_WIDTH`, 64, data and write-mask width
- `STARVE_LIMIT`, 4, consecutive data grants that are allowed while fetch waits; must be at least 1
- `clk` in 1 — single clock, rising edge
- `rst` in 1 — reset; synchronous, active-high
- `i_ncs` in 1 — fetch request, active-low
- `i_nwe` in 1 — fetch write enable, active-low; normally 1
- `i_addr` in ADDR_WIDTH — fetch address
- `i_wdata` in DATA_WIDTH — fetch write data
- `i_wmask` in DATA_WIDTH — fetch bit mask
- `i_stall` out 1 — fetch request not accepted this cycle
- `i_rvalid` out 1 — `i_rdata` carries fetch read data
- `i_rdata` out DATA_WIDTH — fetch read data
- `d_ncs`, `d_nwe`, `d_addr`, `d_wdata`, `d_wmask`, `d_stall`, `d_rvalid`, `d_rdata` — same as the fetch port, for the data requester
- `m_ncs` out 1 — memory select, active-low
- `m_nwe` out 1 — memory write enable, active-low
- `m_addr` out ADDR_WIDTH — memory address
- `m_wdata` out DATA_WIDTH — memory write data
- `m_wmask` out DATA_WIDTH — memory bit mask
- `m_rdata` in DATA_WIDTH — memory read data, valid one cycle after acceptance
- `m_stall` in 1 — memory cannot accept this cycle

## Operation
- **Request:** a requester drives `x_ncs=0`.
- **Acceptance:** a request is accepted in a cycle where it is granted and `m_stall=0`.
- **Stall:** `x_stall = !x_ncs & !(granted & !m_stall)`. A requester holds all request fields stable while `x_stall=1`.
- **States:** IDLE, HOLD_I, HOLD_D.
  - IDLE: grant is decided combinationally from this cycle's requests.
  - HOLD_x: the grant is forced to x. It was granted last cycle and the memory stalled.
- **Grant decision in IDLE:**
  - Only one requester asks: it is granted.
  - Both ask: data is granted, unless `starve_cnt == STARVE_LIMIT`. In that case fetch is granted.
- **Transitions:**
  - Granted request and `m_stall=1` → HOLD_owner.
  - Accepted request → IDLE.
  - In HOLD_x, `x_ncs=1` (requester withdrew) → IDLE. The held grant is dropped and nothing is issued to memory that cycle.
- **`starve_cnt`** (width ⌈log2(STARVE_LIMIT+1)⌉):
  - increments on each data acceptance while `i_ncs=0`;
  - saturates at STARVE_LIMIT;
  - clears on a fetch acceptance or when `i_ncs=1`.
- **Memory outputs:** the `m_*` signals are a combinational mux of the granted port. With no grant, `m_ncs=1` and `m_nwe=1`, and addr/wdata/wmask are 0.
- **Response tracking:** registered `resp_owner`, and `resp_pend` set on an accepted read (`m_nwe=1`). Writes produce no rvalid.
- **Read data return:** `x_rvalid = resp_pend & (resp_owner==x)`. Both `i_rdata` and `d_rdata` carry `m_rdata` unmodified.
- **Reset:** state IDLE, `starve_cnt=0`, `resp_pend=0`.
  - Reset outputs: `m_ncs=1`, `m_nwe=1`, `m_addr=0`, `i_rvalid=0`, `d_rvalid=0`. `x_stall` follows its formula with no grant.
  - Reset asserted mid-transaction discards any pending response and held grant.

## Timing
- Grant, `x_stall` and `m_*` are combinational from requests, state and `m_stall`: zero-cycle arbitration.
- A read accepted in cycle N asserts `x_rvalid` in cycle N+1, with `m_rdata` sampled then.
- Back-to-back acceptances are allowed every cycle. An rvalid for request N and acceptance of request N+1 can share a cycle.
- The grant never changes while in HOLD_x, even if the other requester's priority rises.
- Simultaneous requests with `m_stall=1`: the winner enters HOLD. The loser stays stalled and keeps its request.

## Structure
- Shared package `riscv32ima_pkg` holds:
  - `ADDR_WIDTH`/`DATA_WIDTH` constants;
  - `arb_state_t` enum {IDLE, HOLD_I, HOLD_D};
  - `arb_owner_t` enum {OWN_I, OWN_D}.
- One sub-module, `riscv32ima_arb_starve`: the saturating starvation counter with inputs inc/clr and output `at_limit`.
- Everything else is flat in `riscv32ima_mem_arbiter`.

## Test plan
- **Reset:** hold `rst=1` for 2 cycles with both requesters active. Expect `m_ncs=1`, both rvalids 0, and `i_stall=d_stall=1`.
- **Fetch alone:** fetch read at 0x1000_0000, `m_stall=0`, `m_rdata=0xDEAD_BEEF_0000_0013`. Expect `i_stall=0` in cycle N, then `i_rvalid=1` with that data in N+1 and `d_rvalid=0`.
- **Contention:** both read every cycle, fetch 0x1000_0008, data 0x2000_0000, `STARVE_LIMIT=4`. Expect the grant sequence D,D,D,D,I,D,D,D,D,I; `resp_owner` matches on each rvalid.
- **Stall hold:** data write to 0x2000_0010 with `m_stall=1` for 3 cycles while fetch also requests. Expect `m_addr=0x2000_0010` held throughout and `d_stall=1` for 3 cycles, then accepted. Expect no `d_rvalid` and fetch granted on the next cycle.
- **Withdrawal:** fetch stalled in HOLD_I, then `i_ncs=1`. Expect `m_ncs=1` that cycle, IDLE next, and no rvalid.
- **Reset mid-read:** read accepted in cycle N and `rst=1` in N+1. Expect `i_rvalid=0` and `d_rvalid=0` in N+1 and N+2.
